full_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 15 +
 rtl/full_adder_fa_cell.sv | 11 +
 rtl/full_adder.sv | 46 ++++
 tb/tb_full_adder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared width limit and reference sum function for the adder datapath
package adder_pkg;
  localparam int ADDER_MAX_WIDTH = 64;
  function automatic logic [ADDER_MAX_WIDTH:0] adder_ref(
    input logic [ADDER_MAX_WIDTH-1:0] a,
    input logic [ADDER_MAX_WIDTH-1:0] b,
    input logic cin,
    input int width
  );
    logic [ADDER_MAX_WIDTH-1:0] mask;
    mask = ~(64'hFFFF_FFFF_FFFF_FFFF << width);
    if (width >= ADDER_MAX_WIDTH) mask = '1;
    return {1'b0, a & mask} + {1'b0, b & mask} + {{ADDER_MAX_WIDTH{1'b0}}, cin};
  endfunction
endpackage

// File: rtl/full_adder_fa_cell.sv
// fa_cell: single-bit combinational full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with a single registered output stage
module full_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);
  if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
  end
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_valid;
  assign w_c[0] = Cin;
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    fa_cell u_cell (.a(A[g]), .b(B[g]), .ci(w_c[g]), .s(w_s[g]), .co(w_c[g+1]));
  end
  // Data loads only on valid, so X on idle operands never reaches the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_s;
        r_cout <= w_c[WIDTH];
      end
    end
  end
  assign S         = r_s;
  assign Cout      = r_cout;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of full_adder at WIDTH 1, 8, 16 and 33
module tb_full_adder;
  import adder_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, Cin;
  logic [0:0]  A1, B1, S1;
  logic [7:0]  A8, B8, S8;
  logic [15:0] A16, B16, S16;
  logic [32:0] A33, B33, S33;
  logic C1, C8, C16, C33, V1, V8, V16, V33;
  int tests = 0;
  int fails = 0;
  localparam logic [1:0] TT [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .A(A1), .B(B1),
    .Cin(Cin), .S(S1), .Cout(C1), .out_valid(V1));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid), .A(A8), .B(B8),
    .Cin(Cin), .S(S8), .Cout(C8), .out_valid(V8));
  full_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(in_valid), .A(A16), .B(B16),
    .Cin(Cin), .S(S16), .Cout(C16), .out_valid(V16));
  full_adder #(.WIDTH(33)) u33 (.clk(clk), .rst(rst), .in_valid(in_valid), .A(A33), .B(B33),
    .Cin(Cin), .S(S33), .Cout(C33), .out_valid(V33));

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w1"},  65'({C1, S1, V1}), 65'd0);
    check({tag, "_w8"},  65'({C8, S8, V8}), 65'd0);
    check({tag, "_w16"}, 65'({C16, S16, V16}), 65'd0);
    check({tag, "_w33"}, 65'({C33, S33, V33}), 65'd0);
  endtask

  logic [64:0] e1, e8, e33;
  logic        ev;

  initial begin
    rst = 1'b1; in_valid = 1'b0; Cin = 1'b0;
    A1 = '0; B1 = '0; A8 = '0; B8 = '0; A16 = '0; B16 = '0; A33 = '0; B33 = '0;
    #1;
    check_all_zero("reset_init");
    tick;
    check_all_zero("reset_held");
    rst = 1'b0;
    tick;
    check_all_zero("after_release_idle");
    // exhaustive 1-bit truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      {A1, B1, Cin} = 3'(i);
      in_valid = 1'b1;
      tick;
      check($sformatf("tt_%0d", i), 65'({C1, S1}), 65'(TT[i]));
      check($sformatf("tt_valid_%0d", i), 65'(V1), 65'd1);
    end
    // 8-bit overflow corners
    A8 = 8'hFF; B8 = 8'hFF; Cin = 1'b1;
    tick;
    check("ovf_ff_ff_1", 65'({C8, S8}), 65'h1FF);
    A8 = 8'h80; B8 = 8'h80; Cin = 1'b0;
    tick;
    check("ovf_80_80_0", 65'({C8, S8}), 65'h100);
    A8 = 8'h00; B8 = 8'h00; Cin = 1'b0;
    tick;
    check("zero", 65'({C8, S8}), 65'h000);
    // hold: one valid then three idle cycles with junk operands
    A8 = 8'h12; B8 = 8'h34; Cin = 1'b1;
    tick;
    check("hold_load", 65'({C8, S8}), 65'h047);
    check("hold_load_valid", 65'(V8), 65'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A8 = (i == 1) ? 'x : 8'($urandom);
      B8 = 8'($urandom);
      Cin = (i == 1) ? 1'bx : 1'b1;
      tick;
      check($sformatf("hold_val_%0d", i), 65'({C8, S8}), 65'h047);
      check($sformatf("hold_valid_%0d", i), 65'(V8), 65'd0);
    end
    // 16-bit reset in the middle of a back-to-back stream
    in_valid = 1'b1; Cin = 1'b0;
    A16 = 16'h1234; B16 = 16'h1111;
    tick;
    check("mid_pre", 65'({C16, S16, V16}), {47'd0, 1'b0, 16'h2345, 1'b1});
    A16 = 16'hFFFF; B16 = 16'h0001;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick;
    check_all_zero("rst_flight_lost");
    rst = 1'b0;
    A16 = 16'h8000; B16 = 16'h8000; Cin = 1'b1;
    tick;
    check("mid_post", 65'({C16, S16, V16}), {47'd0, 1'b1, 16'h0001, 1'b1});
    A16 = 16'hFFFF; B16 = 16'h0001; Cin = 1'b0;
    tick;
    check("mid_post2", 65'({C16, S16, V16}), {47'd0, 1'b1, 16'h0000, 1'b1});
    // random regression against the package reference
    e1 = 65'({C1, S1}); e8 = 65'({C8, S8}); e33 = 65'({C33, S33});
    for (int n = 0; n < 10000; n++) begin
      in_valid = 1'($urandom);
      Cin = 1'($urandom);
      A1 = 1'($urandom); B1 = 1'($urandom);
      A8 = 8'($urandom); B8 = 8'($urandom);
      A33 = 33'({$urandom(), $urandom()}); B33 = 33'({$urandom(), $urandom()});
      ev = in_valid;
      if (in_valid) begin
        e1  = adder_ref(64'(A1), 64'(B1), Cin, 1);
        e8  = adder_ref(64'(A8), 64'(B8), Cin, 8);
        e33 = adder_ref(64'(A33), 64'(B33), Cin, 33);
      end
      tick;
      check("rnd_valid", 65'({V1, V8, V33}), {ev, ev, ev});
      check("rnd_w1",  65'({C1, S1}), e1);
      check("rnd_w8",  65'({C8, S8}), e8);
      check("rnd_w33", 65'({C33, S33}), e33);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
